// File: rtl/ctrl_fsm_mc_rv32i.sv
// Multi-cycle sequencer for the RV32I datapath: paces each instruction through
// FETCH/DECODE/EXEC/MEM/WB with handshaked memories, bus timeout and illegal-op trap.
module ctrl_fsm_mc_rv32i #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic [1:0]       rd_sel,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILL
  } cls_e;

  localparam bit TIMEOUT_EN = (MEM_WAIT_MAX != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_EN ? MEM_WAIT_MAX - 1 : 0);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d, dec_cls;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q;
  logic              wait_hit;

  always_comb begin
    dec_cls = C_ILL;
    case (opcode)
      7'h33: dec_cls = C_R;
      7'h13: dec_cls = C_I;
      7'h03: if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) dec_cls = C_LOAD;
      7'h23: if (funct3 <= 3'd2) dec_cls = C_STORE;
      7'h63: if (funct3 != 3'd2 && funct3 != 3'd3) dec_cls = C_BRANCH;
      7'h37: dec_cls = C_LUI;
      7'h17: dec_cls = C_AUIPC;
      7'h6F: dec_cls = C_JAL;
      7'h67: if (funct3 == 3'd0) dec_cls = C_JALR;
      default: dec_cls = C_ILL;
    endcase
  end

  // An ack in the last allowed wait cycle still wins over the timeout.
  assign wait_hit = TIMEOUT_EN && (wait_q == WAIT_LAST);

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    cause_d  = cause_q;
    wait_d   = '0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    rd_sel   = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_req = rst_n;
        if (imem_ack) begin
          ir_we   = rst_n;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_ILL) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ack) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = (cls_q == C_JAL) || (cls_q == C_JALR);
        case (cls_q)
          C_LOAD:        rd_sel = 2'b01;
          C_JAL, C_JALR: rd_sel = 2'b10;
          C_LUI:         rd_sel = 2'b11;
          default:       rd_sel = 2'b00;
        endcase
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      cause_q   <= 2'b00;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      if (pc_we) instret_q <= instret_q + 1'b1;
    end
  end

  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
